// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-subset LCD responder: opcodes, FSM states, DDRAM geometry.
// Display shift support is selected by LCD_SHIFT_EN in the modules that import this package.
package lcd_pkg;

  localparam logic [6:0] LINE0_BASE  = 7'h00;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam int unsigned DDRAM_DEPTH = 32;

  localparam logic [7:0] OP_SET_DDRAM = 8'h80;
  localparam logic [7:0] OP_SET_CGRAM = 8'h40;
  localparam logic [7:0] OP_FUNC_SET  = 8'h20;
  localparam logic [7:0] OP_SHIFT     = 8'h10;
  localparam logic [7:0] OP_DISP_CTRL = 8'h08;
  localparam logic [7:0] OP_ENTRY     = 8'h04;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_CLEAR     = 8'h01;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} lcd_state_e;

  typedef enum logic [3:0] {
    OPC_NONE, OPC_CLEAR, OPC_HOME, OPC_ENTRY, OPC_DISP,
    OPC_SHIFT, OPC_FUNC, OPC_CGRAM, OPC_DDRAM
  } lcd_op_e;

  // Highest set bit selects the instruction.
  function automatic lcd_op_e decode_instr(input logic [7:0] din);
    if ((din & OP_SET_DDRAM) != 8'h00)      return OPC_DDRAM;
    else if ((din & OP_SET_CGRAM) != 8'h00) return OPC_CGRAM;
    else if ((din & OP_FUNC_SET) != 8'h00)  return OPC_FUNC;
    else if ((din & OP_SHIFT) != 8'h00)     return OPC_SHIFT;
    else if ((din & OP_DISP_CTRL) != 8'h00) return OPC_DISP;
    else if ((din & OP_ENTRY) != 8'h00)     return OPC_ENTRY;
    else if ((din & OP_HOME) != 8'h00)      return OPC_HOME;
    else if ((din & OP_CLEAR) != 8'h00)     return OPC_CLEAR;
    else                                    return OPC_NONE;
  endfunction

  // Address counter step with wrap between the two 16-column lines.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == LINE0_BASE + 7'h0F)      return LINE1_BASE;
      else if (ac == LINE1_BASE + 7'h0F) return LINE0_BASE;
      else                               return ac + 7'd1;
    end else begin
      if (ac == LINE0_BASE)              return LINE1_BASE + 7'h0F;
      else if (ac == LINE1_BASE)         return LINE0_BASE + 7'h0F;
      else                               return ac - 7'd1;
    end
  endfunction

  function automatic logic [4:0] cell_of(input logic [6:0] addr);
    return {addr[6], addr[3:0]};
  endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Synchroniser for the asynchronous LCD strobe E, with single-cycle rise/fall pulses.
module lcd_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic en_async,
  output logic en_sync,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], en_async};
  end

  assign en_sync = sh[1];
  assign rise    = sh[1] & ~sh[2];
  assign fall    = ~sh[1] & sh[2];

endmodule

// File: rtl/lcd_ctrl_responder.sv
// HD44780-subset character LCD responder: bus decode, 2x16 DDRAM, AC, flags, busy FSM, scan port.
// Define LCD_SHIFT_EN to enable display shifting (entry-mode S and shift S=1).
module lcd_ctrl_responder
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_CYCLES = 40,
  parameter logic [7:0]  CLEAR_FILL = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_din,
  output logic [7:0] lcd_dout,
  output logic       lcd_doe,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [4:0] cursor_pos,
  output logic [3:0] shift_ofs,
  input  logic [4:0] scan_idx,
  output logic [7:0] scan_char
);

  localparam int unsigned CNT_W = (CMD_CYCLES > 1) ? $clog2(CMD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_CYCLES - 1);

  logic [7:0] ddram [DDRAM_DEPTH];
  lcd_state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [4:0] clr_idx;
  logic [6:0] ac;
  logic       id;
  logic       e_sync, e_rise, e_fall;
  logic       cap_rs, cap_rw;
  logic [7:0] cap_din;
  logic       rd_rs, rd_now, rd_sel;
  logic [7:0] rd_data;
  logic [4:0] cur_cell, scan_cell;
  logic       accept, is_clear, clear_done, wr_data;
  lcd_op_e    opc;

  lcd_strobe_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_async (lcd_en),
    .en_sync  (e_sync),
    .rise     (e_rise),
    .fall     (e_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_rs  <= 1'b0;
      cap_rw  <= 1'b0;
      cap_din <= '0;
    end else if (e_sync) begin
      cap_rs  <= lcd_rs;
      cap_rw  <= lcd_rw;
      cap_din <= lcd_din;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign cur_cell   = cell_of(ac);
  assign cursor_pos = cur_cell;
  assign opc        = decode_instr(cap_din);
  // Busy-flag reads never start execution, so they are honoured in any state.
  assign accept     = e_fall && (state == ST_IDLE) && !(!cap_rs && cap_rw);
  assign is_clear   = accept && !cap_rs && !cap_rw && (cap_din == OP_CLEAR);
  assign wr_data    = accept && cap_rs && !cap_rw;
  assign clear_done = (state == ST_CLEAR) && (clr_idx == 5'(DDRAM_DEPTH - 1));

  // Read data is taken from the live bus on the rise cycle, captured rs afterwards.
  assign rd_now  = e_rise && lcd_rw;
  assign rd_sel  = rd_now ? lcd_rs : rd_rs;
  assign rd_data = rd_sel ? ddram[cur_cell] : {busy, ac};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_doe  <= 1'b0;
      lcd_dout <= '0;
      rd_rs    <= 1'b0;
    end else begin
      if (e_fall)      lcd_doe <= 1'b0;
      else if (rd_now) begin
        lcd_doe <= 1'b1;
        rd_rs   <= lcd_rs;
      end
      if (rd_now || (lcd_doe && !e_fall)) lcd_dout <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      clr_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= (state == ST_EXEC) ? cnt + 1'b1 : '0;
      clr_idx <= (state == ST_CLEAR) ? clr_idx + 5'd1 : '0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept) state_n = is_clear ? ST_CLEAR : ST_EXEC;
      ST_EXEC:  if (cnt == CNT_LAST) state_n = ST_IDLE;
      ST_CLEAR: if (clear_done) state_n = ST_EXEC;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac        <= LINE0_BASE;
      id        <= 1'b1;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
    end else if (clear_done) begin
      ac <= LINE0_BASE;
      id <= 1'b1;
    end else if (accept) begin
      if (cap_rs) ac <= ac_step(ac, id);
      else begin
        case (opc)
          OPC_DDRAM: ac <= cap_din[6:0];
          OPC_SHIFT: if (!cap_din[3]) ac <= ac_step(ac, cap_din[2]);
          OPC_DISP:  {disp_on, cursor_on, blink_on} <= cap_din[2:0];
          OPC_ENTRY: id <= cap_din[1];
          OPC_HOME:  ac <= LINE0_BASE;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)  ddram[clr_idx] <= CLEAR_FILL;
    else if (wr_data)       ddram[cur_cell] <= cap_din;
  end

`ifdef LCD_SHIFT_EN
  logic [3:0] shift_r;
  logic       entry_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= '0;
      entry_s <= 1'b0;
    end else if (clear_done) begin
      shift_r <= '0;
    end else if (accept) begin
      if (wr_data && entry_s) shift_r <= id ? shift_r - 4'd1 : shift_r + 4'd1;
      else if (!cap_rs) begin
        case (opc)
          OPC_SHIFT: if (cap_din[3]) shift_r <= cap_din[2] ? shift_r + 4'd1 : shift_r - 4'd1;
          OPC_ENTRY: entry_s <= cap_din[0];
          OPC_HOME:  shift_r <= '0;
          default:   ;
        endcase
      end
    end
  end

  assign shift_ofs = shift_r;
  assign scan_cell = {scan_idx[4], scan_idx[3:0] + shift_r};
`else
  assign shift_ofs = '0;
  assign scan_cell = scan_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_char <= '0;
    else        scan_char <= ddram[scan_cell];
  end

endmodule

// File: tb/tb_lcd_ctrl_responder.sv
// Scoreboard bench for lcd_ctrl_responder; covers both LCD_SHIFT_EN builds.
module tb_lcd_ctrl_responder;

  localparam int unsigned CMD      = 36;
  localparam int unsigned CLR_BUSY = 32 + CMD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_din, lcd_dout;
  logic       lcd_doe, busy, disp_on, cursor_on, blink_on;
  logic [4:0] cursor_pos, scan_idx;
  logic [3:0] shift_ofs;
  logic [7:0] scan_char;

  lcd_ctrl_responder #(.CMD_CYCLES(CMD), .CLEAR_FILL(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_din(lcd_din), .lcd_dout(lcd_dout), .lcd_doe(lcd_doe), .busy(busy),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .cursor_pos(cursor_pos), .shift_ofs(shift_ofs), .scan_idx(scan_idx), .scan_char(scan_char)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t        stat_q[$];
  exp_t        bus_q[$];
  int unsigned busy_q[$];
  exp_t        mon_e;
  int unsigned checks = 0;
  int unsigned passes = 0;
  logic        stat_req = 1'b0;
  logic        stat_vld = 1'b0;
  logic        doe_prev = 1'b0;
  int unsigned bcnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] probe(input int sel);
    case (sel)
      0:       return {7'b0, busy};
      1:       return {3'b0, cursor_pos};
      2:       return {5'b0, disp_on, cursor_on, blink_on};
      3:       return {4'b0, shift_ofs};
      4:       return scan_char;
      5:       return {7'b0, lcd_doe};
      default: return lcd_dout;
    endcase
  endfunction

  always @(posedge clk) stat_vld <= stat_req;

  // Monitor: status/scan samples, bus read presentations, busy run lengths.
  always @(negedge clk) begin
    if (stat_vld) begin
      if (stat_q.size() == 0) check("stat_unexpected", 32'(stat_q.size()), 32'd1);
      else begin
        mon_e = stat_q.pop_front();
        check(mon_e.name, 32'(probe(mon_e.sel)), 32'(mon_e.exp));
      end
    end
    if (lcd_doe && !doe_prev) begin
      if (bus_q.size() == 0) check("bus_unexpected", 32'(lcd_doe), 32'd0);
      else begin
        mon_e = bus_q.pop_front();
        check(mon_e.name, 32'(lcd_dout), 32'(mon_e.exp));
      end
    end
    doe_prev = lcd_doe;
    if (!rst_n) bcnt = 0;
    else if (busy) bcnt++;
    else if (bcnt != 0) begin
      if (busy_q.size() == 0) check("busy_unexpected", bcnt, 32'd0);
      else check("busy_len", bcnt, busy_q.pop_front());
      bcnt = 0;
    end
  end

  task automatic expect_stat(input int sel, input logic [7:0] exp, input string nm);
    exp_t e;
    e.name = nm; e.sel = sel; e.exp = exp;
    stat_q.push_back(e);
    stat_req = 1'b1;
    @(posedge clk);
    #1 stat_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_scan(input logic [4:0] idx, input logic [7:0] exp, input string nm);
    scan_idx = idx;
    expect_stat(4, exp, nm);
  endtask

  task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_din = d;
    @(negedge clk);
    lcd_en = 1'b1;
    repeat (6) @(negedge clk);
    lcd_en = 1'b0;
    repeat (5) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic lcd_write(input logic rs, input logic [7:0] d, input int unsigned blen);
    if (blen != 0) busy_q.push_back(blen);
    bus_xfer(rs, 1'b0, d);
  endtask

  task automatic lcd_read(input logic rs, input logic [7:0] exp, input string nm, input int unsigned blen);
    exp_t e;
    e.name = nm; e.sel = 6; e.exp = exp;
    bus_q.push_back(e);
    if (blen != 0) busy_q.push_back(blen);
    bus_xfer(rs, 1'b1, 8'h00);
  endtask

  task automatic wait_idle(input string nm);
    int unsigned n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d, input string nm);
    lcd_write(1'b0, d, CMD);
    wait_idle(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_din = '0; scan_idx = '0;
    repeat (3) @(negedge clk);
    expect_stat(0, 8'h00, "rst_busy");
    expect_stat(1, 8'h00, "rst_cursor");
    expect_stat(2, 8'h00, "rst_flags");
    expect_stat(3, 8'h00, "rst_shift");
    expect_stat(4, 8'h00, "rst_scan");
    expect_stat(5, 8'h00, "rst_doe");
    expect_stat(6, 8'h00, "rst_dout");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    lcd_read(1'b0, 8'h00, "bf_after_reset", 0);
    expect_stat(5, 8'h00, "doe_released");

    lcd_write(1'b0, 8'h01, CLR_BUSY);
    wait_idle("idle_clear");
    for (int unsigned i = 0; i < 32; i++) expect_scan(5'(i), 8'h20, $sformatf("clear_cell%0d", i));
    expect_stat(1, 8'h00, "clear_ac");

    cmd(8'h06, "idle_entry_inc");
    cmd(8'h8F, "idle_ddram_0f");
    lcd_write(1'b1, 8'h41, CMD); wait_idle("idle_wr_A");
    lcd_write(1'b1, 8'h42, CMD); wait_idle("idle_wr_B");
    lcd_read(1'b0, 8'h41, "ac_after_AB", 0);
    expect_stat(1, 8'h11, "cursor_after_AB");
    expect_scan(5'd15, 8'h41, "cell_0F_A");
    expect_scan(5'd16, 8'h42, "cell_40_B");

    cmd(8'h8F, "idle_ddram_0f_again");
    lcd_read(1'b1, 8'h41, "data_read_A", CMD);
    wait_idle("idle_data_read");
    lcd_read(1'b0, 8'h40, "ac_after_data_read", 0);

    cmd(8'h04, "idle_entry_dec");
    cmd(8'h80, "idle_ddram_00");
    lcd_write(1'b1, 8'h5A, CMD); wait_idle("idle_wr_Z");
    lcd_read(1'b0, 8'h4F, "ac_dec_wrap_00_4F", 0);
    expect_scan(5'd0, 8'h5A, "cell_00_Z");
    expect_stat(1, 8'h1F, "cursor_4F");

    lcd_write(1'b0, 8'h80, CMD);
    lcd_read(1'b0, 8'h80, "bf_mid_busy", 0);
    lcd_write(1'b1, 8'h51, 0);
    wait_idle("idle_dropped");
    expect_scan(5'd0, 8'h5A, "dropped_write_cell");
    lcd_read(1'b0, 8'h00, "dropped_write_ac", 0);

    cmd(8'h0F, "idle_disp_ctrl");
    expect_stat(2, 8'h07, "flags_dcb");

    cmd(8'h1C, "idle_disp_shift");
`ifdef LCD_SHIFT_EN
    expect_stat(3, 8'h01, "shift_ofs_1");
    expect_scan(5'd14, 8'h41, "shift_scan_0E");
    expect_scan(5'd0, 8'h20, "shift_scan_00");
`else
    expect_stat(3, 8'h00, "shift_ofs_0");
    expect_scan(5'd0, 8'h5A, "noshift_scan_00");
`endif

    cmd(8'h85, "idle_ddram_05");
    cmd(8'h02, "idle_home");
    expect_stat(1, 8'h00, "home_ac");
    expect_stat(3, 8'h00, "home_shift");
    cmd(8'h14, "idle_cursor_right");
    expect_stat(1, 8'h01, "cursor_right");
    cmd(8'h10, "idle_cursor_left1");
    cmd(8'h10, "idle_cursor_left2");
    expect_stat(1, 8'h1F, "cursor_left_wrap");

    lcd_write(1'b0, 8'h01, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    expect_stat(0, 8'h00, "rst_mid_clear_busy");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_scan(5'd0, 8'h20, "partial_clear_cell00");
    expect_scan(5'd15, 8'h41, "partial_clear_cell0F");
    expect_scan(5'd16, 8'h42, "partial_clear_cell40");
    lcd_read(1'b0, 8'h00, "ac_after_mid_reset", 0);

    repeat (5) @(negedge clk);
    check("pending_stat", 32'(stat_q.size()), 32'd0);
    check("pending_bus", 32'(bus_q.size()), 32'd0);
    check("pending_busy", 32'(busy_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
